ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction fetch stage of the NPC core; sits directly upstream of the decode unit.
- Owns the PC and issues one instruction-memory request at a time over a valid/ready handshake.
- Registers the returned instruction and presents {pc, instruction} to decode over a valid/ready handshake.
- Handles PC redirects from execute/writeback, discarding any wrong-path fetch in flight.

Parameters:
- RESET_PC, 32'h8000_0000, PC value after reset
- XLEN, 32, address/data width

Ports:
- clk  input  1  core clock, rising edge
- rst  input  1  synchronous, active-high reset
- redirect_valid  input  1  next-PC override this cycle (branch/jump/trap)
- redirect_pc  input  XLEN  override target; bits [1:0] ignored (treated as 0)
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  XLEN  fetch address, word aligned
- imem_resp_valid  input  1  response data valid (exactly one per accepted request)
- imem_resp_data  input  32  fetched instruction
- out_valid  output  1  instruction valid to decode
- out_ready  input  1  decode consumes
- out_pc  output  XLEN  PC of presented instruction
- out_instruction  output  32  presented instruction
- busy  output  1  request outstanding (state WAIT or DRAIN)

Behaviour:
- Clock is clk; reset is synchronous, active-high on rst. All state updates on the rising edge of clk.
- Reset values:
  - pc = RESET_PC, state = REQ.
  - out_valid = 0, out_pc = 0, out_instruction = 0.
  - imem_req_valid = 0 while rst is high.
- Output decode:
  - imem_req_valid = (state == REQ) && !rst.
  - imem_req_addr = {pc[XLEN-1:2], 2'b00}.
  - busy = (state == WAIT) || (state == DRAIN).
- At most one request outstanding; no new request until the previous response has been received.
- States and transitions (redirect has priority over every other event):
  - REQ:
    - req handshake, no redirect -> WAIT.
    - req handshake + redirect -> pc <= redirect_pc, go to DRAIN (old-PC response must be discarded).
    - no handshake + redirect -> pc <= redirect_pc, stay REQ. Request is sampled only on handshake, so the address may change while valid stays high.
  - WAIT:
    - resp_valid, no redirect -> capture out_instruction <= resp_data, out_pc <= pc, out_valid <= 1, go to HOLD.
    - redirect + resp_valid in the same cycle -> drop the data, pc <= redirect_pc, go to REQ.
    - redirect without resp_valid -> pc <= redirect_pc, go to DRAIN.
  - HOLD (out_valid = 1; out_pc and out_instruction stable until handshake):
    - out_valid && out_ready, no redirect -> out_valid <= 0, pc <= pc + 4, go to REQ.
    - redirect (with or without out_ready) -> out_valid <= 0, pc <= redirect_pc, go to REQ. The held instruction is squashed.
  - DRAIN:
    - resp_valid -> discard, go to REQ.
    - redirect while draining -> pc <= redirect_pc, stay DRAIN. A second redirect overwrites the target; only one response is still owed.
- Latency with zero-wait memory: request accepted in cycle N, response in N+1, out_valid in N+2. Back-to-back throughput is one instruction per 3 cycles; this is accepted for the multi-cycle NPC.
- PC arithmetic is modulo 2^XLEN: pc + 4 wraps from 32'hFFFF_FFFC to 0.
- A response arriving in REQ or HOLD is a protocol violation. It is ignored and must not corrupt state; an assertion flags it.
- Reset mid-operation (in WAIT or DRAIN): return to REQ at RESET_PC. The memory model is also reset by rst, so no stale response is expected.

Decomposition:
- Shared package npc_pkg:
  - fetch state enum {REQ, WAIT, HOLD, DRAIN}
  - RESET_PC default
  - INST_NOP constant = 32'h0000_0013
- No sub-module required. PC next-value mux (redirect / pc+4 / hold) stays inline as a small always block.

Test Plan:
1. Reset release, zero-wait memory returning 32'h00000013 at every address -> imem_req_addr sequence 8000_0000, 8000_0004, 8000_0008; out_valid pulses every 3 cycles with the matching out_pc.
2. out_ready held low 5 cycles in HOLD -> out_valid stays 1, out_pc/out_instruction unchanged, no new imem request. out_ready high -> next request addr = out_pc + 4.
3. Redirect to 8000_0100 in the same cycle the req handshakes (memory latency 3) -> busy stays high; returned data for the old PC never reaches out_valid; next request addr = 8000_0100.
4. Redirect coincident with imem_resp_valid in WAIT -> data dropped, out_valid stays 0, next cycle imem_req_valid = 1 with addr = redirect_pc.
5. Redirect in HOLD with out_ready = 0 -> out_valid = 0 next cycle; redirect_pc = 8000_0203 yields imem_req_addr = 8000_0200.
6. pc = FFFF_FFFC consumed -> next imem_req_addr = 0000_0000. rst asserted during DRAIN -> next request addr = 8000_0000, out_valid = 0.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared NPC core types and constants.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package npc_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        FS_REQ   = 2'd0,
        FS_WAIT  = 2'd1,
        FS_HOLD  = 2'd2,
        FS_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;

endpackage

// File: rtl/ifu_fetch.sv
// Instruction fetch: owns the PC, one imem request in flight, registers {pc, insn} for decode.
// Latency: request accepted in N, response N+1, out_valid N+2 (zero-wait memory).
// Backpressure: holds the instruction until out_ready; no new request while holding or waiting.
module ifu_fetch
    import npc_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_instruction,
    output logic            busy
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] out_pc_q, out_pc_d;
    logic [31:0]     out_inst_q, out_inst_d;
    logic            pc_incr;
    logic            req_hs;
    logic [XLEN-1:0] redirect_tgt;

    assign redirect_tgt    = redirect_pc & ALIGN_MASK;
    assign imem_req_valid  = (state_q == FS_REQ) && !rst;
    assign imem_req_addr   = pc_q & ALIGN_MASK;
    assign req_hs          = imem_req_valid && imem_req_ready;
    assign busy            = (state_q == FS_WAIT) || (state_q == FS_DRAIN);
    assign out_valid       = out_valid_q;
    assign out_pc          = out_pc_q;
    assign out_instruction = out_inst_q;

    // Next-state and output-register update; redirect outranks every other event.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_inst_d  = out_inst_q;
        pc_incr     = 1'b0;
        case (state_q)
            FS_REQ: begin
                // A request launched alongside a redirect is wrong-path: drain its response.
                if (req_hs) begin
                    state_d = redirect_valid ? FS_DRAIN : FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (redirect_valid) begin
                    // Response in the same cycle settles the debt; otherwise it is still owed.
                    state_d = imem_resp_valid ? FS_REQ : FS_DRAIN;
                end else if (imem_resp_valid) begin
                    out_valid_d = 1'b1;
                    out_pc_d    = pc_q;
                    out_inst_d  = imem_resp_data;
                    state_d     = FS_HOLD;
                end
            end
            FS_HOLD: begin
                if (redirect_valid) begin
                    out_valid_d = 1'b0;
                    state_d     = FS_REQ;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    pc_incr     = 1'b1;
                    state_d     = FS_REQ;
                end
            end
            FS_DRAIN: begin
                // Redirect here only retargets the PC; the single owed response still ends the drain.
                if (imem_resp_valid) begin
                    state_d = FS_REQ;
                end
            end
            default: state_d = FS_REQ;
        endcase
    end

    // PC mux: redirect target, sequential advance on consume, else hold.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = redirect_tgt;
        end else if (pc_incr) begin
            pc_d = pc_q + XLEN'(4);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FS_REQ;
            pc_q        <= RESET_PC;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_inst_q  <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_inst_q  <= out_inst_d;
        end
    end

    // A response is only legal while one is owed.
    a_resp_when_owed: assert property (@(posedge clk) disable iff (rst)
        imem_resp_valid |-> (state_q == FS_WAIT || state_q == FS_DRAIN));

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: vector table, directed corner sequences, randomized run vs. scoreboard.
// Latency: n/a.
// Backpressure: randomized imem_req_ready / out_ready and memory latency.
module tb_ifu_fetch;
    import npc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_pc;
    logic [31:0] out_instruction;
    logic        busy;

    ifu_fetch #(.XLEN(32), .RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_instruction(out_instruction), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Instruction memory contents: a fixed scramble of the address, or NOP everywhere.
    logic mem_nop = 1'b1;
    function automatic logic [31:0] mem_data(input logic [31:0] a);
        if (mem_nop) return INST_NOP;
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Memory model: answers each accepted request after lat cycles (lat >= 1).
    int          lat = 1;
    logic        mem_pend = 1'b0;
    int          mem_cnt = 0;
    logic [31:0] mem_addr = '0;
    logic        mem_next_resp = 1'b0;

    task automatic mem_step();
        mem_next_resp = 1'b0;
        if (rst) begin
            mem_pend = 1'b0;
        end else begin
            if (imem_resp_valid) mem_pend = 1'b0;
            if (imem_req_valid && imem_req_ready) begin
                mem_pend = 1'b1;
                mem_cnt  = lat;
                mem_addr = imem_req_addr;
            end
            if (mem_pend) begin
                if (mem_cnt == 1) mem_next_resp = 1'b1;
                else mem_cnt--;
            end
        end
    endtask

    task automatic mem_drive();
        imem_resp_valid = mem_next_resp;
        imem_resp_data  = mem_next_resp ? mem_data(mem_addr) : 32'hDEAD_BEEF;
    endtask

    // Scoreboard: next fetch PC, the outstanding request (and whether it went stale),
    // and the instruction currently owed to decode.
    logic [31:0] m_pc = 32'h8000_0000;
    logic        m_infl = 1'b0;
    logic        m_stale = 1'b0;
    logic [31:0] m_infl_addr = '0;
    logic        m_have = 1'b0;
    logic [31:0] m_opc = '0;
    logic [31:0] m_oinst = '0;

    task automatic model_step();
        logic exp_rv, hs, had;
        exp_rv = !rst && !m_infl && !m_have;
        chk("m_req_valid", {31'd0, imem_req_valid}, {31'd0, exp_rv});
        if (exp_rv) chk("m_req_addr", imem_req_addr, m_pc);
        chk("m_out_valid", {31'd0, out_valid}, {31'd0, m_have});
        if (m_have) begin
            chk("m_out_pc", out_pc, m_opc);
            chk("m_out_inst", out_instruction, m_oinst);
        end
        chk("m_busy", {31'd0, busy}, {31'd0, m_infl});
        hs  = exp_rv && imem_req_ready;
        had = m_have;
        if (rst) begin
            m_pc = 32'h8000_0000; m_infl = 1'b0; m_have = 1'b0;
        end else begin
            if (imem_resp_valid && m_infl) begin
                m_infl = 1'b0;
                if (!m_stale && !redirect_valid) begin
                    m_have = 1'b1; m_opc = m_infl_addr; m_oinst = mem_data(m_infl_addr);
                end
            end
            if (hs) begin
                m_infl = 1'b1; m_infl_addr = m_pc; m_stale = redirect_valid;
            end
            if (had && (out_ready || redirect_valid)) begin
                m_have = 1'b0;
                if (!redirect_valid) m_pc = m_pc + 32'd4;
            end
            if (redirect_valid) begin
                m_pc = {redirect_pc[31:2], 2'b00};
                if (m_infl) m_stale = 1'b1;
            end
        end
    endtask

    task automatic cyc_begin();
        @(negedge clk);
    endtask

    task automatic cyc_end();
        model_step();
        mem_step();
        @(posedge clk);
        #1;
        mem_drive();
    endtask

    typedef struct {
        logic        rst;
        logic        rrdy;
        logic        ordy;
        logic        e_rv;
        logic [31:0] e_addr;
        logic        e_ov;
        logic [31:0] e_opc;
        logic [31:0] e_oinst;
        logic        e_busy;
    } vec_t;

    vec_t vec[15];
    logic got;

    initial begin
        // Reset release, zero-wait NOP memory, then a 5-cycle decode stall.
        vec[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,    1'b0};
        vec[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 1'b0, 32'h0,         32'h0,    1'b0};
        vec[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,    1'b1};
        vec[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0000, INST_NOP, 1'b0};
        vec[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0004, 1'b0, 32'h0,         32'h0,    1'b0};
        vec[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,    1'b1};
        vec[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0004, INST_NOP, 1'b0};
        vec[7]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h8000_0008, 1'b0, 32'h0,         32'h0,    1'b0};
        vec[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,    1'b1};
        for (int i = 9; i < 14; i++)
            vec[i] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,      1'b1, 32'h8000_0008, INST_NOP, 1'b0};
        vec[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8000_0008, INST_NOP, 1'b0};

        @(posedge clk);
        #1;
        for (int i = 0; i < 15; i++) begin
            rst = vec[i].rst; imem_req_ready = vec[i].rrdy; out_ready = vec[i].ordy;
            cyc_begin();
            chk($sformatf("v%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, vec[i].e_rv});
            if (vec[i].e_rv) chk($sformatf("v%0d_req_addr", i), imem_req_addr, vec[i].e_addr);
            chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vec[i].e_ov});
            if (vec[i].e_ov || vec[i].rst) begin
                chk($sformatf("v%0d_out_pc", i), out_pc, vec[i].e_opc);
                chk($sformatf("v%0d_out_inst", i), out_instruction, vec[i].e_oinst);
            end
            chk($sformatf("v%0d_busy", i), {31'd0, busy}, {31'd0, vec[i].e_busy});
            cyc_end();
        end
        mem_nop = 1'b0;

        // Redirect on the request handshake, memory latency 3: old response is drained.
        lat = 3; redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
        cyc_begin();
        chk("t3_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("t3_req_addr", imem_req_addr, 32'h8000_000C);
        cyc_end();
        redirect_valid = 1'b0; imem_req_ready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc_begin();
            chk("t3_no_out", {31'd0, out_valid}, 32'd0);
            if (imem_req_valid) begin
                got = 1'b1;
                chk("t3_drain_cycles", i, 3);
                chk("t3_new_addr", imem_req_addr, 32'h8000_0100);
            end else begin
                chk("t3_busy", {31'd0, busy}, 32'd1);
            end
            cyc_end();
            if (got) break;
        end
        if (!got) begin errors++; checks++; $display("FAIL t3_timeout: got no request expected one"); end

        // Redirect coincident with the response in WAIT.
        lat = 2; imem_req_ready = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc_begin();
            cyc_end();
            imem_req_ready = 1'b0;
            if (imem_resp_valid) begin got = 1'b1; break; end
        end
        if (!got) begin errors++; checks++; $display("FAIL t4_timeout: got no response expected one"); end
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
        cyc_begin();
        chk("t4_busy", {31'd0, busy}, 32'd1);
        cyc_end();
        redirect_valid = 1'b0;
        cyc_begin();
        chk("t4_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t4_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("t4_req_addr", imem_req_addr, 32'h8000_0300);
        cyc_end();

        // Redirect in HOLD with out_ready low; unaligned target.
        lat = 1; imem_req_ready = 1'b1; out_ready = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc_begin();
            if (out_valid) begin
                got = 1'b1;
                chk("t5_out_pc", out_pc, 32'h8000_0300);
                chk("t5_out_inst", out_instruction, mem_data(32'h8000_0300));
            end
            cyc_end();
            if (got) break;
        end
        if (!got) begin errors++; checks++; $display("FAIL t5_timeout: got no out_valid expected one"); end
        redirect_valid = 1'b1; redirect_pc = 32'h8000_0203;
        cyc_begin();
        chk("t5_still_hold", {31'd0, out_valid}, 32'd1);
        cyc_end();
        redirect_valid = 1'b0; imem_req_ready = 1'b0;
        cyc_begin();
        chk("t5_squashed", {31'd0, out_valid}, 32'd0);
        chk("t5_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("t5_req_addr", imem_req_addr, 32'h8000_0200);
        cyc_end();

        // PC wrap at the top of the address space, then reset during DRAIN.
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        cyc_begin();
        cyc_end();
        redirect_valid = 1'b0; imem_req_ready = 1'b1; out_ready = 1'b1; lat = 1;
        got = 1'b0;
        for (int i = 0; i < 8; i++) begin
            cyc_begin();
            if (out_valid) begin
                got = 1'b1;
                chk("t6_top_pc", out_pc, 32'hFFFF_FFFC);
            end
            cyc_end();
            if (got) break;
        end
        if (!got) begin errors++; checks++; $display("FAIL t6_timeout: got no out_valid expected one"); end
        lat = 3; redirect_valid = 1'b1; redirect_pc = 32'h8000_0400;
        cyc_begin();
        chk("t6_wrap_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("t6_wrap_addr", imem_req_addr, 32'h0000_0000);
        cyc_end();
        redirect_valid = 1'b0; imem_req_ready = 1'b0;
        cyc_begin();
        chk("t6_drain_busy", {31'd0, busy}, 32'd1);
        cyc_end();
        rst = 1'b1;
        cyc_begin();
        chk("t6_rst_no_req", {31'd0, imem_req_valid}, 32'd0);
        cyc_end();
        rst = 1'b0;
        cyc_begin();
        chk("t6_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("t6_rst_req_addr", imem_req_addr, 32'h8000_0000);
        chk("t6_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        cyc_end();

        // Randomized traffic against the scoreboard.
        for (int i = 0; i < 3000; i++) begin
            rst            = ($urandom_range(0, 199) == 0);
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF8 | 32'($urandom_range(0, 7)))
                                                          : 32'($urandom);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            out_ready      = 1'($urandom_range(0, 1));
            lat            = $urandom_range(1, 4);
            cyc_begin();
            cyc_end();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
